// File: rtl/scan_frame_scheduler.sv
// scan_frame_scheduler: sequences repeated full-array scans at a programmed
// frame period, waits for scan completion, hands each frame to readout and
// holds off the next scan until readout acks (single-buffer pixel RAM).
// Optional feature macro: SCAN_TIMEOUT_EN (scan watchdog, limit TIMEOUT_CYCLES).
module scan_frame_scheduler #(
  parameter int unsigned NB_FRAMES      = 16,
  parameter int unsigned NB_PERIOD      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_start,
  input  logic                 i_cmd_stop,
  input  logic [NB_FRAMES-1:0] i_n_frames,
  input  logic [NB_PERIOD-1:0] i_period,
  output logic                 o_start_scan,
  input  logic                 i_scan_ready,
  output logic                 o_frame_valid,
  input  logic                 i_frame_ack,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [NB_FRAMES-1:0] o_frame_cnt,
  output logic                 o_overrun,
  output logic                 o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_SCAN,
    S_HANDOFF,
    S_WAIT_PERIOD
  } state_t;

  state_t               state_q, state_d;
  logic [NB_FRAMES-1:0] n_frames_q, n_frames_d;
  logic [NB_FRAMES-1:0] frame_cnt_q, frame_cnt_d;
  logic [NB_PERIOD-1:0] period_q, period_d;
  logic [NB_PERIOD-1:0] per_cnt_q, per_cnt_d, per_inc;
  logic                 stop_q, stop_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic                 done_q, done_d;
  logic                 entry_q, entry_d;
  logic                 rdy_q, rdy_prev_q;
  logic                 scan_edge;
  logic                 run_end;
  logic                 wd_fire;

  assign scan_edge = rdy_q & ~rdy_prev_q;
  assign per_inc   = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1;
  assign run_end   = stop_q | i_cmd_stop |
                     ((n_frames_q != '0) && (frame_cnt_q == n_frames_q));

`ifdef SCAN_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog: cleared while issuing the start pulse, counts WAIT_SCAN cycles
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_START) begin
      wd_d = '0;
    end else if (state_q == S_WAIT_SCAN && wd_q != '1) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_fire = (state_q == S_WAIT_SCAN) &&
                   ((32'(wd_q) + 32'd1) >= TIMEOUT_CYCLES);

  // Watchdog counter register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Next-state, counters and sticky flags
  always_comb begin
    state_d     = state_q;
    n_frames_d  = n_frames_q;
    period_d    = period_q;
    frame_cnt_d = frame_cnt_q;
    per_cnt_d   = per_inc;
    stop_d      = stop_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    entry_d     = 1'b0;

    if (state_q != S_IDLE && i_cmd_stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_start) begin
          n_frames_d  = i_n_frames;
          period_d    = i_period;
          frame_cnt_d = '0;
          overrun_d   = 1'b0;
          timeout_d   = 1'b0;
          stop_d      = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT_SCAN;
      end
      S_WAIT_SCAN: begin
        if (scan_edge) begin
          state_d = S_HANDOFF;
        end else if (wd_fire) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_HANDOFF: begin
        if (i_frame_ack) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
          entry_d     = 1'b1;
          state_d     = S_WAIT_PERIOD;
        end
      end
      S_WAIT_PERIOD: begin
        if (run_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (entry_q && period_q != '0 && per_cnt_q >= period_q) overrun_d = 1'b1;
          // per_inc is the elapsed count seen by the START cycle, so the
          // next pulse lands exactly period cycles after the previous one
          if (per_inc >= period_q) state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Period counter reads 0 during the START cycle of every frame
    if (state_d == S_START) per_cnt_d = '0;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      n_frames_q  <= '0;
      period_q    <= '0;
      frame_cnt_q <= '0;
      per_cnt_q   <= '0;
      stop_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      entry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_frames_q  <= n_frames_d;
      period_q    <= period_d;
      frame_cnt_q <= frame_cnt_d;
      per_cnt_q   <= per_cnt_d;
      stop_q      <= stop_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      entry_q     <= entry_d;
    end
  end

  // Scan-ready synchroniser stage plus previous value for edge detection
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rdy_q      <= 1'b0;
      rdy_prev_q <= 1'b0;
    end else begin
      rdy_q      <= i_scan_ready;
      rdy_prev_q <= rdy_q;
    end
  end

  assign o_start_scan  = (state_q == S_START);
  assign o_frame_valid = (state_q == S_HANDOFF);
  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = done_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_overrun     = overrun_q;
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_scan_frame_scheduler.sv
// Bench for scan_frame_scheduler: timestamp-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_scan_frame_scheduler;
  localparam int NBF   = 16;
  localparam int NBP   = 24;
  localparam int TO    = 500;
  localparam int NEVER = 32'h7fffffff;

  logic           clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_cmd_start = 1'b0, i_cmd_stop = 1'b0;
  logic [NBF-1:0] i_n_frames = '0;
  logic [NBP-1:0] i_period = '0;
  logic           o_start_scan, o_frame_valid, o_busy, o_done, o_overrun, o_timeout;
  logic [NBF-1:0] o_frame_cnt;
  logic           i_scan_ready = 1'b0;
  logic           i_frame_ack;
  logic           auto_ack = 1'b0, stray_ack = 1'b0;

  assign i_frame_ack = auto_ack | stray_ack;

  always #5 clk = ~clk;

  scan_frame_scheduler #(.NB_FRAMES(NBF), .NB_PERIOD(NBP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .i_rst(i_rst), .i_cmd_start(i_cmd_start), .i_cmd_stop(i_cmd_stop),
    .i_n_frames(i_n_frames), .i_period(i_period), .o_start_scan(o_start_scan),
    .i_scan_ready(i_scan_ready), .o_frame_valid(o_frame_valid), .i_frame_ack(i_frame_ack),
    .o_busy(o_busy), .o_done(o_done), .o_frame_cnt(o_frame_cnt),
    .o_overrun(o_overrun), .o_timeout(o_timeout)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (timestamps of frame milestones) -------
  int cyc = 0, p;
  bit m_run = 0, m_stopf = 0, m_ovr = 0, m_to = 0, r_p = 0, r_pp = 0;
  int m_n = 0, m_p = 0, m_cnt = 0;
  int t_start = -1, t_valid = NEVER, t_acked = NEVER, t_done = -1;

  always @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      m_run = 0; m_stopf = 0; m_ovr = 0; m_to = 0; m_cnt = 0; r_p = 0; r_pp = 0;
      t_start = -1; t_valid = NEVER; t_acked = NEVER; t_done = -1;
    end else begin
      p = cyc;
      cyc++;
      if (!m_run) begin
        if (i_cmd_start) begin
          m_run = 1; m_n = int'(i_n_frames); m_p = int'(i_period);
          m_cnt = 0; m_ovr = 0; m_to = 0; m_stopf = 0;
          t_start = cyc; t_valid = NEVER; t_acked = NEVER;
        end
      end else begin
        if (i_cmd_stop) m_stopf = 1;
        if (p > t_start && p < t_valid) begin
          if (r_p && !r_pp) t_valid = cyc;
`ifdef SCAN_TIMEOUT_EN
          else if (p - t_start >= TO) begin m_run = 0; m_to = 1; t_done = cyc; end
`endif
        end else if (p >= t_valid && p < t_acked) begin
          if (i_frame_ack) begin t_acked = cyc; m_cnt = (m_cnt + 1) % 65536; end
        end else if (p >= t_acked) begin
          if (m_stopf || (m_n != 0 && m_cnt == m_n)) begin
            m_run = 0; t_done = cyc;
          end else begin
            if (p == t_acked && m_p != 0 && p - t_start >= m_p) m_ovr = 1;
            if (cyc >= t_start + m_p) begin t_start = cyc; t_valid = NEVER; t_acked = NEVER; end
          end
        end
      end
      r_pp = r_p;
      r_p  = i_scan_ready;
    end
  end

  // ---------------- per-cycle compare + event recording --------------------
  int starts[$];
  int n_done = 0, done_cyc = -1;

  always @(negedge clk) begin
    check("cyc_busy",  o_busy,        m_run);
    check("cyc_start", o_start_scan,  m_run && cyc == t_start);
    check("cyc_valid", o_frame_valid, m_run && cyc >= t_valid && cyc < t_acked);
    check("cyc_done",  o_done,        cyc == t_done);
    check("cyc_cnt",   o_frame_cnt,   m_cnt);
    check("cyc_ovr",   o_overrun,     m_ovr);
    check("cyc_to",    o_timeout,     m_to);
    if (o_start_scan) starts.push_back(cyc);
    if (o_done) begin n_done++; done_cyc = cyc; end
  end

  // ---------------- scan module and readout models -------------------------
  int scan_len = 400, ack_delay = 0, sc_left = 0, vcnt = 0;
  bit sc_act = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (i_rst) begin
        i_scan_ready = 0; sc_act = 0; vcnt = 0; auto_ack = 0;
      end else begin
        if (o_start_scan) begin
          i_scan_ready = 0; sc_act = (scan_len != 0); sc_left = scan_len;
        end else if (sc_act) begin
          sc_left--;
          if (sc_left == 0) begin i_scan_ready = 1; sc_act = 0; end
        end
        if (o_frame_valid) begin
          if (vcnt >= ack_delay) auto_ack = 1;
          vcnt++;
        end else begin
          vcnt = 0; auto_ack = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic cmd(input int nf, input int per, input bit with_stop);
    tick();
    i_n_frames = NBF'(nf); i_period = NBP'(per);
    i_cmd_start = 1; i_cmd_stop = with_stop;
    tick();
    i_cmd_start = 0; i_cmd_stop = 0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int d0 = n_done;
    int k = 0;
    while (n_done == d0 && k < limit) begin tick(); k++; end
    check(nm, n_done - d0, 1);
  endtask

  task automatic wait_starts(input int n, input int limit, input string nm);
    int k = 0;
    while (starts.size() < n && k < limit) begin tick(); k++; end
    check(nm, starts.size(), n);
  endtask

  // ---------------- directed scenarios --------------------------------------
  initial begin
    repeat (3) tick();
    check("rst_busy",  o_busy, 0);
    check("rst_start", o_start_scan, 0);
    check("rst_valid", o_frame_valid, 0);
    check("rst_done",  o_done, 0);
    check("rst_cnt",   o_frame_cnt, 0);
    check("rst_flags", {o_overrun, o_timeout}, 0);
    i_rst = 0;
    repeat (3) tick();

    // 1: three frames, period 1000, 400-cycle scan, immediate ack
    scan_len = 400; ack_delay = 0; starts.delete();
    cmd(3, 1000, 0);
    wait_done(5000, "t1_done");
    repeat (1200) tick();
    check("t1_nstart", starts.size(), 3);
    check("t1_gap1",   starts[1] - starts[0], 1000);
    check("t1_gap2",   starts[2] - starts[1], 1000);
    check("t1_cnt",    o_frame_cnt, 3);
    check("t1_ovr",    o_overrun, 0);

    // 2: period shorter than scan -> back-to-back after ack, overrun
    starts.delete();
    cmd(2, 100, 0);
    wait_done(3000, "t2_done");
    check("t2_nstart", starts.size(), 2);
    check("t2_gap",    starts[1] - starts[0], 404);
    check("t2_ovr",    o_overrun, 1);
    check("t2_cnt",    o_frame_cnt, 2);

    // 3: continuous, stop during scan of frame 5
    scan_len = 20; starts.delete();
    cmd(0, 0, 0);
    wait_starts(5, 2000, "t3_five");
    check("t3_gap", starts[1] - starts[0], 24);
    repeat (5) tick();
    i_cmd_stop = 1; tick(); i_cmd_stop = 0;
    wait_done(2000, "t3_done");
    repeat (50) tick();
    check("t3_nstart", starts.size(), 5);
    check("t3_cnt",    o_frame_cnt, 5);
    check("t3_busy",   o_busy, 0);

    // 4: readout holds ack off 3000 cycles; stray acks outside handoff
    scan_len = 50; ack_delay = 3000; starts.delete();
    cmd(2, 100, 0);
    wait_starts(1, 100, "t4_first");
    repeat (1500) tick();
    check("t4_held",   o_frame_valid, 1);
    check("t4_nonext", starts.size(), 1);
    wait_starts(2, 3000, "t4_second");
    ack_delay = 10;
    check("t4_gap", starts[1] - starts[0], 3054);
    tick(); stray_ack = 1; tick(); stray_ack = 0;
    wait_done(2000, "t4_done");
    tick(); stray_ack = 1; tick(); stray_ack = 0;
    repeat (5) tick();
    check("t4_cnt",  o_frame_cnt, 2);
    check("t4_idle", o_busy, 0);

    // 5: asynchronous reset while waiting for the scan, then rerun of 1
    scan_len = 400; ack_delay = 0; starts.delete();
    cmd(3, 1000, 0);
    repeat (100) tick();
    #2 i_rst = 1;
    #1;
    check("t5_busy",  o_busy, 0);
    check("t5_outs",  {o_start_scan, o_frame_valid, o_done, o_overrun, o_timeout}, 0);
    repeat (3) tick();
    i_rst = 0;
    repeat (2) tick();
    starts.delete();
    cmd(3, 1000, 0);
    wait_done(5000, "t5_done");
    check("t5_nstart", starts.size(), 3);
    check("t5_gap",    starts[2] - starts[1], 1000);
    check("t5_cnt",    o_frame_cnt, 3);

    // 7: start+stop together in idle (start wins); start while busy ignored
    scan_len = 10; starts.delete();
    cmd(2, 0, 1);
    repeat (3) tick();
    i_n_frames = 9; i_cmd_start = 1; tick(); i_cmd_start = 0;
    wait_done(500, "t7_done");
    check("t7_cnt", o_frame_cnt, 2);

    // 6: scan never completes
    scan_len = 0; starts.delete();
    cmd(1, 0, 0);
`ifdef SCAN_TIMEOUT_EN
    wait_done(700, "t6_done");
    check("t6_to",    o_timeout, 1);
    check("t6_cnt",   o_frame_cnt, 0);
    check("t6_when",  done_cyc - starts[0], TO + 1);
`else
    repeat (700) tick();
    check("t6_busy", o_busy, 1);
    check("t6_to",   o_timeout, 0);
    check("t6_cnt",  o_frame_cnt, 0);
    i_rst = 1; repeat (2) tick(); i_rst = 0; tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
